// File: rtl/video_pkg.sv
// Shared video types and helpers for the scaler datapath.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package video_pkg;

    localparam int HDMI_720P_W = 1280;
    localparam int HDMI_720P_H = 720;

    // Source pixel layout: {B5,G5,R5}
    typedef struct packed {
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } rgb555_t;

    // Output pixel layout: {R8,G8,B8}
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        HOLD  = 2'd1,
        DONE  = 2'd2
    } sync_state_t;

    // Replicate the top bits so full-scale 5'h1F maps to 8'hFF
    function automatic rgb888_t expand555(input rgb555_t p);
        rgb888_t o;
        o.r = {p.r, p.r[4:2]};
        o.g = {p.g, p.g[4:2]};
        o.b = {p.b, p.b[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/line_bram.sv
// Simple dual-port line store, one write port and one registered read port.
// Latency: read data valid 1 cycle after rd_addr; same-address read/write returns old data.
// Backpressure: none, both ports accept every cycle.
module line_bram #(
    parameter int DEPTH_LOG2 = 12,
    parameter int DW         = 15
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DW-1:0]         wr_dat,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DW-1:0]         rd_dat
);

    logic [DW-1:0] mem [2**DEPTH_LOG2];

    // Read-before-write: the read samples the array before this edge's write lands
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/line_buffer_scaler.sv
// Line-ring scaler: stores source lines, replays them integer-scaled and centred in the output frame.
// Latency: 2 cycles from out_cx/out_cy to out_rgb/out_active.
// Backpressure: none on the output side; pause_src stalls the source while frame sync is held.
module line_buffer_scaler #(
    parameter int          SRC_W      = 256,
    parameter int          SRC_H      = 224,
    parameter int          PIX_W      = 15,
    parameter int          LINES_LOG2 = 4,
    parameter int          SCALE      = 3,
    parameter int          OUT_X0     = 256,
    parameter int          OUT_Y0     = 24,
    parameter int          SYNC_LINE  = 2,
    parameter int          REARM_LINE = 200,
    parameter int          MAX_HOLD   = 2000000,
    parameter logic [23:0] BORDER     = 24'h303030
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             src_valid,
    input  logic [8:0]       src_x,
    input  logic [8:0]       src_y,
    input  logic [PIX_W-1:0] src_pix,
    input  logic             out_de,
    input  logic [10:0]      out_cx,
    input  logic [9:0]       out_cy,
    input  logic             overlay_en,
    input  logic [PIX_W-1:0] overlay_pix,
    output logic [23:0]      out_rgb,
    output logic             out_active,
    output logic             pause_src,
    output logic             underrun,
    output logic             overrun,
    output logic             sync_timeout
);
    import video_pkg::*;

    localparam int AW  = LINES_LOG2 + 8;
    localparam int HCW = $clog2(MAX_HOLD + 1);

    localparam logic [8:0]     SRC_W9   = 9'(SRC_W);
    localparam logic [8:0]     SRC_H9   = 9'(SRC_H);
    localparam logic [8:0]     X_LAST9  = 9'(SRC_W - 1);
    localparam logic [8:0]     SYNC9    = 9'(SYNC_LINE);
    localparam logic [8:0]     REARM9   = 9'(REARM_LINE);
    localparam logic [10:0]    X0_11    = 11'(OUT_X0);
    localparam logic [9:0]     Y0_10    = 10'(OUT_Y0);
    localparam logic [11:0]    X0_12    = 12'(OUT_X0);
    localparam logic [11:0]    X1_12    = 12'(OUT_X0 + SRC_W * SCALE);
    localparam logic [11:0]    Y0_12    = 12'(OUT_Y0);
    localparam logic [11:0]    Y1_12    = 12'(OUT_Y0 + SRC_H * SCALE);
    localparam logic [2:0]     SUB_LAST = 3'(SCALE - 1);
    localparam logic [9:0]     RING10   = 10'(2 ** LINES_LOG2);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    // Write side
    logic          wr_en, line_done;
    logic [8:0]    src_lines, lines_nxt;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [PIX_W-1:0] rd_dat;

    // Read side
    logic       frame_act, win, line_start, under_hit;
    logic [8:0] sx_q, sy_q, cur_sx, cur_sy, nxt_sx;
    logic [2:0] xsub_q, ysub_q, cur_xsub, cur_ysub, nxt_xsub;
    logic       win_q, bord_q, ovl_q;
    logic [PIX_W-1:0] ovl_pix_q;
    logic [23:0] pix_rgb;

    // Frame sync
    sync_state_t    state_q, state_d;
    logic [HCW-1:0] hold_cnt;
    logic           hold_par, tmo_set;

    assign wr_en     = src_valid && (src_x < SRC_W9) && (src_y < SRC_H9);
    assign line_done = wr_en && (src_x == X_LAST9);
    assign lines_nxt = (src_lines == SRC_H9) ? src_lines : src_lines + 9'd1;
    assign wr_addr   = {src_y[LINES_LOG2-1:0], src_x[7:0]};

    // Completed-line count; the first pixel of a source frame restarts it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            src_lines <= '0;
        end else if (src_valid && (src_x == 9'd0) && (src_y == 9'd0)) begin
            src_lines <= '0;
        end else if (line_done) begin
            src_lines <= lines_nxt;
        end
    end

    assign frame_act  = ({2'b00, out_cy} >= Y0_12) && ({2'b00, out_cy} < Y1_12);
    assign win        = frame_act && ({1'b0, out_cx} >= X0_12) && ({1'b0, out_cx} < X1_12);
    assign line_start = (out_cx == X0_11);

    // Source coordinate for the current output pixel; stored counters hold the next expected value
    always_comb begin
        cur_sx   = sx_q;
        cur_xsub = xsub_q;
        cur_sy   = sy_q;
        cur_ysub = ysub_q;
        nxt_sx   = sx_q;
        nxt_xsub = xsub_q;
        if (line_start) begin
            cur_sx   = '0;
            cur_xsub = '0;
            if (out_cy == Y0_10) begin
                cur_sy   = '0;
                cur_ysub = '0;
            end else if (ysub_q == SUB_LAST) begin
                cur_sy   = sy_q + 9'd1;
                cur_ysub = '0;
            end else begin
                cur_ysub = ysub_q + 3'd1;
            end
        end
        if (cur_xsub == SUB_LAST) begin
            nxt_sx   = cur_sx + 9'd1;
            nxt_xsub = '0;
        end else begin
            nxt_sx   = cur_sx;
            nxt_xsub = cur_xsub + 3'd1;
        end
    end

    // Scale counters move only on enabled output pixels; the line counter once per line
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sx_q   <= '0;
            xsub_q <= '0;
            sy_q   <= '0;
            ysub_q <= '0;
        end else if (out_de) begin
            sx_q   <= nxt_sx;
            xsub_q <= nxt_xsub;
            if (line_start) begin
                sy_q   <= cur_sy;
                ysub_q <= cur_ysub;
            end
        end
    end

    assign under_hit = (cur_sy >= src_lines);
    assign rd_addr   = {cur_sy[LINES_LOG2-1:0], cur_sx[7:0]};

    line_bram #(
        .DEPTH_LOG2(AW),
        .DW        (PIX_W)
    ) u_bram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_dat (src_pix),
        .rd_addr(rd_addr),
        .rd_dat (rd_dat)
    );

    // Side-band that travels alongside the BRAM read
    always_ff @(posedge clk) begin
        if (!resetn) begin
            win_q     <= 1'b0;
            bord_q    <= 1'b0;
            ovl_q     <= 1'b0;
            ovl_pix_q <= '0;
        end else begin
            win_q     <= out_de && win;
            bord_q    <= under_hit;
            ovl_q     <= overlay_en;
            ovl_pix_q <= overlay_pix;
        end
    end

    // Colour select: overlay beats stored data; a line not yet written shows border
    always_comb begin
        pix_rgb = BORDER;
        if (win_q) begin
            if (ovl_q) begin
                pix_rgb = expand555(rgb555_t'(ovl_pix_q));
            end else if (!bord_q) begin
                pix_rgb = expand555(rgb555_t'(rd_dat));
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_rgb    <= '0;
            out_active <= 1'b0;
        end else begin
            out_rgb    <= pix_rgb;
            out_active <= win_q;
        end
    end

    // Sticky error flags
    always_ff @(posedge clk) begin
        if (!resetn) begin
            underrun     <= 1'b0;
            overrun      <= 1'b0;
            sync_timeout <= 1'b0;
        end else begin
            if (out_de && win && under_hit) begin
                underrun <= 1'b1;
            end
            if (line_done && frame_act && ({1'b0, lines_nxt} > ({1'b0, sy_q} + RING10))) begin
                overrun <= 1'b1;
            end
            if (tmo_set) begin
                sync_timeout <= 1'b1;
            end
        end
    end

    // Sync state register plus hold length counter and its parity
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ARMED;
            hold_cnt <= '0;
            hold_par <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == HOLD) begin
                hold_cnt <= hold_cnt + HCW'(1);
                hold_par <= ~hold_par;
            end else begin
                hold_cnt <= '0;
                hold_par <= 1'b0;
            end
        end
    end

    // Sync next state; exit on an odd parity cycle so the pause length is even
    always_comb begin
        state_d   = state_q;
        pause_src = 1'b0;
        tmo_set   = 1'b0;
        case (state_q)
            ARMED: begin
                if (line_done && (src_y == SYNC9)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                pause_src = 1'b1;
                if ((out_cy == Y0_10) && hold_par) begin
                    state_d = DONE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d = DONE;
                    tmo_set = 1'b1;
                end
            end
            DONE: begin
                if (src_valid && (src_y == REARM9)) begin
                    state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

endmodule

// File: tb/tb_line_buffer_scaler.sv
// Directed bench for line_buffer_scaler: two instances share stimulus, one with a short hold timeout.
// Latency: outputs are checked two cycles after the output coordinate is driven.
// Backpressure: pause_src lengths are measured cycle by cycle.
module tb_line_buffer_scaler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        src_valid;
    logic [8:0]  src_x, src_y;
    logic [14:0] src_pix;
    logic        out_de;
    logic [10:0] out_cx;
    logic [9:0]  out_cy;
    logic        overlay_en;
    logic [14:0] overlay_pix;

    logic [23:0] out_rgb, out_rgb_b;
    logic        out_active, pause_src, underrun, overrun, sync_timeout;
    logic        out_active_b, pause_b, underrun_b, overrun_b, sync_timeout_b;

    int total = 0;
    int bad   = 0;
    int na, nb;

    always #5 clk = ~clk;

    line_buffer_scaler dut (
        .clk(clk), .resetn(resetn),
        .src_valid(src_valid), .src_x(src_x), .src_y(src_y), .src_pix(src_pix),
        .out_de(out_de), .out_cx(out_cx), .out_cy(out_cy),
        .overlay_en(overlay_en), .overlay_pix(overlay_pix),
        .out_rgb(out_rgb), .out_active(out_active), .pause_src(pause_src),
        .underrun(underrun), .overrun(overrun), .sync_timeout(sync_timeout)
    );

    line_buffer_scaler #(.MAX_HOLD(100)) dut_b (
        .clk(clk), .resetn(resetn),
        .src_valid(src_valid), .src_x(src_x), .src_y(src_y), .src_pix(src_pix),
        .out_de(out_de), .out_cx(out_cx), .out_cy(out_cy),
        .overlay_en(overlay_en), .overlay_pix(overlay_pix),
        .out_rgb(out_rgb_b), .out_active(out_active_b), .pause_src(pause_b),
        .underrun(underrun_b), .overrun(overrun_b), .sync_timeout(sync_timeout_b)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wpix(input int x, input int y);
        src_valid = 1'b1;
        src_x     = 9'(x);
        src_y     = 9'(y);
        src_pix   = 15'((y * 256 + x) & 32'h7FFF);
        step();
    endtask

    task automatic wline(input int y);
        for (int x = 0; x < 256; x++) wpix(x, y);
        src_valid = 1'b0;
    endtask

    // Only the last pixel of a line, enough to complete it
    task automatic wlast(input int y);
        wpix(255, y);
        src_valid = 1'b0;
    endtask

    task automatic drv(input int cx, input int cy, input logic de);
        out_cx = 11'(cx);
        out_cy = 10'(cy);
        out_de = de;
        step();
    endtask

    task automatic idle();
        out_de = 1'b0;
        step();
    endtask

    initial begin
        resetn = 1'b0; src_valid = 1'b0; src_x = '0; src_y = '0; src_pix = '0;
        out_de = 1'b0; out_cx = '0; out_cy = '0; overlay_en = 1'b0; overlay_pix = '0;
        repeat (3) step();

        chk("rst_rgb", out_rgb, 24'h0);
        chk("rst_active", 24'(out_active), 24'h0);
        chk("rst_pause", 24'(pause_src), 24'h0);
        chk("rst_underrun", 24'(underrun), 24'h0);
        chk("rst_overrun", 24'(overrun), 24'h0);
        chk("rst_timeout", 24'(sync_timeout), 24'h0);
        chk("rst_pause_b", 24'(pause_b), 24'h0);

        resetn = 1'b1;
        step();

        // Lines 0..2; completing line 2 starts the hold
        wline(0);
        wline(1);
        wline(2);
        chk("pause_on", 24'(pause_src), 24'h1);

        // Output frame reaches line 24 in hold cycle 1001; B times out after 100
        na = 0;
        nb = 0;
        for (int i = 0; i < 1100; i++) begin
            if (i == 1001) out_cy = 10'd24;
            if (pause_src) na++;
            if (pause_b) nb++;
            step();
        end
        chk("hold_len", 24'(na), 24'd1002);
        chk("hold_len_b", 24'(nb), 24'd100);
        chk("pause_off", 24'(pause_src), 24'h0);
        chk("pause_off_b", 24'(pause_b), 24'h0);
        chk("no_timeout", 24'(sync_timeout), 24'h0);
        chk("timeout_b", 24'(sync_timeout_b), 24'h1);

        out_cy = 10'd0;
        wline(3);

        // Frame 1: source pixel (1,0) covers a 3x3 block at cx 259..261, cy 24..26
        for (int cy = 24; cy <= 26; cy++) begin
            for (int cx = 256; cx <= 261; cx++) begin
                drv(cx, cy, 1'b1);
                if (cx >= 259) begin
                    idle();
                    chk($sformatf("px_%0d_%0d", cx, cy), out_rgb, 24'h080000);
                    chk($sformatf("act_%0d_%0d", cx, cy), 24'(out_active), 24'h1);
                end
            end
        end

        drv(255, 27, 1'b1);
        idle();
        chk("left_edge", out_rgb, 24'h303030);
        chk("left_edge_act", 24'(out_active), 24'h0);
        for (int cx = 256; cx <= 1023; cx++) begin
            drv(cx, 27, 1'b1);
            if (cx == 256) begin
                idle();
                chk("px_0_1", out_rgb, 24'h004200);
            end
            if (cx == 265) begin
                idle();
                chk("px_3_1", out_rgb, 24'h184200);
            end
        end
        idle();
        chk("px_255_1", out_rgb, 24'hFF7B00);
        chk("right_edge_act", 24'(out_active), 24'h1);
        drv(1024, 27, 1'b1);
        idle();
        chk("border_1024", out_rgb, 24'h303030);
        chk("border_1024_act", 24'(out_active), 24'h0);

        for (int cy = 28; cy <= 32; cy++) drv(256, cy, 1'b1);
        drv(256, 33, 1'b1);
        idle();
        chk("px_0_3", out_rgb, 24'h00C600);
        chk("underrun_clear", 24'(underrun), 24'h0);

        // Source line 4 not yet written (src_lines = 4)
        drv(256, 34, 1'b1);
        drv(256, 35, 1'b1);
        drv(256, 36, 1'b1);
        idle();
        chk("under_px_4", out_rgb, 24'h303030);
        chk("under_act_4", 24'(out_active), 24'h1);
        chk("underrun_set", 24'(underrun), 24'h1);
        drv(256, 37, 1'b1);
        drv(256, 38, 1'b1);
        drv(256, 39, 1'b1);
        idle();
        chk("under_px_5", out_rgb, 24'h303030);

        // Fill lines 4 and 5, then replay a fresh frame
        wline(4);
        wline(5);
        for (int cy = 24; cy <= 38; cy++) drv(256, cy, 1'b1);
        drv(256, 39, 1'b1);
        overlay_en  = 1'b1;
        overlay_pix = 15'h7FFF;
        drv(257, 39, 1'b1);
        chk("px_0_5", out_rgb, 24'h004208);
        drv(1100, 39, 1'b1);
        chk("overlay_in", out_rgb, 24'hFFFFFF);
        chk("overlay_in_act", 24'(out_active), 24'h1);
        idle();
        chk("overlay_out", out_rgb, 24'h303030);
        chk("overlay_out_act", 24'(out_active), 24'h0);
        chk("underrun_sticky", 24'(underrun), 24'h1);
        overlay_en = 1'b0;

        // Reader parked on source line 5 inside the active frame; writer runs ahead
        for (int y = 6; y <= 20; y++) wlast(y);
        chk("overrun_16", 24'(overrun), 24'h0);
        wlast(21);
        chk("overrun_17", 24'(overrun), 24'h1);

        // Re-arm, enter hold again, then reset mid-hold
        src_valid = 1'b1;
        src_x     = 9'd0;
        src_y     = 9'd200;
        step();
        src_valid = 1'b0;
        wlast(2);
        chk("rearm_pause", 24'(pause_src), 24'h1);
        chk("rearm_pause_b", 24'(pause_b), 24'h1);
        resetn = 1'b0;
        step();
        chk("reset_hold_pause", 24'(pause_src), 24'h0);
        chk("reset_overrun", 24'(overrun), 24'h0);
        chk("reset_underrun", 24'(underrun), 24'h0);
        chk("reset_timeout_b", 24'(sync_timeout_b), 24'h0);
        chk("reset_rgb", out_rgb, 24'h0);
        resetn = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
